// File: rtl/seq_detector_param.sv
// seq_detector_param
//   Serial pattern detector with a run-time selectable pattern, length and
//   overlap mode. It keeps a MAX_LEN-bit shift history of accepted bits and a
//   saturating fill count. A match raises z for one cycle, registered, in the
//   cycle after the accepting edge.
//
// Parameters
//   MAX_LEN   maximum pattern length in bits (2..16)
//   CNT_W     match counter width in bits (1..32)
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   en         x is accepted on an edge only when en=1
//   x          serial data bit
//   clr        synchronous clear of history, fill count, z and match_cnt;
//              it wins over en, and the bit presented with it is dropped
//   pattern    target sequence; pattern[len-1] is the oldest bit, pattern[0]
//              the newest
//   len        active pattern length; 0, 1 or >MAX_LEN never matches
//   overlap    1 = overlapping detection, 0 = restart after each match
//   z          one-cycle match pulse (registered)
//   match_cnt  saturating match count
//
// Build option
//   SEQ_DETECTOR_MATCH_CNT_EN  when defined, the match counter is built.
//                              Otherwise match_cnt is tied to 0 and no
//                              counter flops exist.

module seq_detector_param #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               x,
  input  logic               clr,
  input  logic [MAX_LEN-1:0] pattern,
  input  logic [4:0]         len,
  input  logic               overlap,
  output logic               z,
  output logic [CNT_W-1:0]   match_cnt
);

  localparam logic [4:0] FILL_MAX = 5'(MAX_LEN);

  logic [MAX_LEN-1:0] hist_q;
  logic [MAX_LEN-1:0] hist_nxt;
  logic [MAX_LEN-1:0] len_mask;
  logic [4:0]         fill_q;
  logic [4:0]         fill_nxt;
  logic               len_ok;
  logic               match;
  logic               z_q;

  // The match is judged on the history as it will be after this edge, with
  // the incoming bit included. That way a pattern completes on the edge
  // that accepts its last bit.
  always_comb begin
    hist_nxt = {hist_q[MAX_LEN-2:0], x};
    fill_nxt = (fill_q == FILL_MAX) ? fill_q : fill_q + 5'd1;
    len_ok   = (len >= 5'd2) && (len <= FILL_MAX);
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (5'(i) < len);
    end
    match = en && !clr && len_ok && (fill_nxt >= len) &&
            ((hist_nxt & len_mask) == (pattern & len_mask));
  end

  // After a non-overlapping match the history bits are left as they are.
  // Clearing the fill count is enough: it keeps those bits from ever
  // contributing to a later match.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
      fill_q <= '0;
      z_q    <= 1'b0;
    end else if (clr) begin
      hist_q <= '0;
      fill_q <= '0;
      z_q    <= 1'b0;
    end else begin
      z_q <= match;
      if (en) begin
        hist_q <= hist_nxt;
        fill_q <= (match && !overlap) ? 5'd0 : fill_nxt;
      end
    end
  end

  assign z = z_q;

`ifdef SEQ_DETECTOR_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (match && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign match_cnt = cnt_q;
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Testbench for seq_detector_param.
// Two instances share all inputs. dut0 uses CNT_W=8 and dut1 uses CNT_W=2.
// A queue-based reference model predicts z and match_cnt for every edge.
// Directed checks then compare pulse totals with hand-derived values.

module tb_seq_detector_param;

`ifdef SEQ_DETECTOR_MATCH_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       x = 1'b0;
  logic       clr = 1'b0;
  logic       overlap = 1'b0;
  logic [7:0] pattern = '0;
  logic [4:0] len = '0;
  logic       z0, z1;
  logic [7:0] cnt0;
  logic [1:0] cnt1;

  always #5 clk = ~clk;

  seq_detector_param #(.MAX_LEN(8), .CNT_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .en(en), .x(x), .clr(clr), .pattern(pattern),
    .len(len), .overlap(overlap), .z(z0), .match_cnt(cnt0)
  );

  seq_detector_param #(.MAX_LEN(8), .CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .x(x), .clr(clr), .pattern(pattern),
    .len(len), .overlap(overlap), .z(z1), .match_cnt(cnt1)
  );

  typedef struct {
    logic       z;
    logic [7:0] c0;
    logic [1:0] c1;
  } exp_t;

  exp_t        sb[$];
  bit          mbits[$];
  int unsigned m_c0 = 0;
  int unsigned m_c1 = 0;
  int          n_assert = 0;
  int          n_fail = 0;
  int          zcount = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // The reference keeps accepted bits in a queue, newest at the back.
  task automatic model_edge(output exp_t e);
    bit m;
    m = 1'b0;
    if (clr) begin
      mbits.delete();
      m_c0 = 0;
      m_c1 = 0;
    end else if (en) begin
      mbits.push_back(x);
      if (mbits.size() > 8) void'(mbits.pop_front());
      if (len >= 2 && len <= 8 && mbits.size() >= int'(len)) begin
        m = 1'b1;
        for (int i = 0; i < int'(len); i++)
          if (mbits[mbits.size()-1-i] != pattern[i]) m = 1'b0;
      end
      if (m) begin
        if (m_c0 < 255) m_c0++;
        if (m_c1 < 3) m_c1++;
        if (!overlap) mbits.delete();
      end
    end
    e.z  = m;
    e.c0 = CNT_ON ? m_c0[7:0] : 8'd0;
    e.c1 = CNT_ON ? m_c1[1:0] : 2'd0;
  endtask

  task automatic step(input logic e_i, input logic x_i);
    exp_t ex, got;
    en = e_i;
    x  = x_i;
    model_edge(ex);
    sb.push_back(ex);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk("z0", 32'(z0), 32'(got.z));
    chk("z1", 32'(z1), 32'(got.z));
    chk("cnt0", 32'(cnt0), 32'(got.c0));
    chk("cnt1", 32'(cnt1), 32'(got.c1));
    if (z0) zcount++;
    en  = 1'b0;
    clr = 1'b0;
  endtask

  task automatic clear_all();
    clr = 1'b1;
    step(1'b0, 1'b0);
    zcount = 0;
  endtask

  task automatic send(input logic [31:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i]);
  endtask

  initial begin
    logic [7:0] a5;
    int unsigned saved;

    #2;
    chk("reset_z", 32'(z0), 32'd0);
    chk("reset_cnt", 32'(cnt0), 32'd0);
    #10 rst_n = 1'b1;

    // Non-overlapping detection of 1010.
    len = 5'd4; pattern = 8'b1010; overlap = 1'b0;
    clear_all();
    send(32'b10101010, 8);
    chk("r028_zpulses", 32'(zcount), 32'd2);
    chk("r028_cnt", 32'(cnt0), CNT_ON ? 32'd2 : 32'd0);

    // Overlapping detection of 1010.
    overlap = 1'b1;
    clear_all();
    send(32'b10101010, 8);
    chk("r029_zpulses", 32'(zcount), 32'd3);
    chk("r029_cnt", 32'(cnt0), CNT_ON ? 32'd3 : 32'd0);

    // 8-bit pattern delivered with en gaps between bits.
    len = 5'd8; pattern = 8'hA5; overlap = 1'b0;
    clear_all();
    a5 = 8'hA5;
    for (int i = 7; i >= 0; i--) begin
      step(1'b1, a5[i]);
      for (int g = 0; g < 3; g++) step(1'b0, 1'($urandom));
    end
    chk("r030_zpulses", 32'(zcount), 32'd1);

    // A clr issued mid-sequence discards the partial sequence and its bit.
    len = 5'd4; pattern = 8'b1010;
    clear_all();
    send(32'b101, 3);
    chk("r031_prezero", 32'(zcount), 32'd0);
    clr = 1'b1;
    step(1'b1, 1'b0);
    send(32'b1010, 4);
    chk("r031_zpulses", 32'(zcount), 32'd1);
    chk("r031_cnt", 32'(cnt0), CNT_ON ? 32'd1 : 32'd0);

    // Counter saturation on the narrow instance, then an async reset mid-stream.
    overlap = 1'b1; len = 5'd2; pattern = 8'b11;
    clear_all();
    send(32'b111111, 6);
    chk("r032_zpulses", 32'(zcount), 32'd5);
    chk("r032_cnt_sat", 32'(cnt1), CNT_ON ? 32'd3 : 32'd0);
    chk("r032_cnt_wide", 32'(cnt0), CNT_ON ? 32'd5 : 32'd0);
    step(1'b1, 1'b1);
    chk("r032_zpre", 32'(z0), 32'd1);
    rst_n = 1'b0;
    mbits.delete(); m_c0 = 0; m_c1 = 0;
    #1;
    chk("r032_rst_z0", 32'(z0), 32'd0);
    chk("r032_rst_z1", 32'(z1), 32'd0);
    chk("r032_rst_cnt0", 32'(cnt0), 32'd0);
    chk("r032_rst_cnt1", 32'(cnt1), 32'd0);
    #2 rst_n = 1'b1;

    // The first edge after reset accepts the first bit.
    zcount = 0;
    send(32'b11, 2);
    chk("r024_zpulses", 32'(zcount), 32'd1);

    // An illegal len never matches and leaves the counter unchanged.
    saved = CNT_ON ? m_c0 : 0;
    zcount = 0;
    pattern = 8'h00;
    len = 5'd0;
    for (int i = 0; i < 32; i++) step(1'b1, 1'($urandom));
    len = 5'd1;
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
    len = 5'd9;
    for (int i = 0; i < 32; i++) step(1'b1, 1'($urandom));
    chk("r033_zpulses", 32'(zcount), 32'd0);
    chk("r033_cnt", 32'(cnt0), saved);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
